chnl_responder: RTL and testbench

Receiving end of the channel valid/ready interface: accepts 32-bit words from a channel initiator, buffers them in a show-ahead FIFO, and reports free space on `ch_margin`. One instance per channel sits at the input of the multi-channel data transmitter. It presents buffered words to the downstream arbiter through a second valid/ready port.

---
 rtl/chnl_responder_if.sv | 25 ++
 rtl/chnl_responder.sv | 88 ++++++++
 tb/tb_chnl_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/chnl_responder_if.sv
// Channel responder port bundle: initiator-facing push side plus arbiter-facing pop side.
// The master modport is the driving side (initiator/arbiter); the slave modport is the responder.
interface chnl_responder_if #(
  parameter int DW = 32
);
  logic          en;
  logic [DW-1:0] ch_data;
  logic          ch_valid;
  logic          ch_ready;
  logic [5:0]    ch_margin;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          ovf_err;

  modport master (
    output en, ch_data, ch_valid, out_ready,
    input  ch_ready, ch_margin, out_data, out_valid, ovf_err
  );

  modport slave (
    input  en, ch_data, ch_valid, out_ready,
    output ch_ready, ch_margin, out_data, out_valid, ovf_err
  );
endinterface

// File: rtl/chnl_responder.sv
// Per-channel show-ahead FIFO with free-space report; accepted word is on out_data one cycle later.
// ch_ready drops when full or disabled (drain continues); a stall held at full for >1023 cycles sets sticky ovf_err.
module chnl_responder #(
  parameter int DEPTH = 32,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  chnl_responder_if.slave  bus
);
  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] FULL = 6'(DEPTH);
  localparam logic [9:0] WD_TC = 10'd1023;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [5:0]    cnt;
  logic [9:0]    wd_cnt;
  logic          ovf_q;

  logic          is_full;
  logic          is_empty;
  logic          ready_c;
  logic          push;
  logic          pop;
  logic          stall;

  always_comb begin
    is_full  = (cnt == FULL);
    is_empty = (cnt == 6'd0);
    // Ready deliberately ignores a same-cycle pop so it stays a short path.
    ready_c  = bus.en & ~is_full & ~rstn;
    push     = bus.ch_valid & ready_c;
    pop      = ~is_empty & bus.out_ready;
    stall    = bus.ch_valid & is_full;
  end

  assign bus.ch_ready  = ready_c;
  assign bus.out_valid = ~is_empty;
  assign bus.out_data  = mem[rp];
  assign bus.ch_margin = FULL - cnt;
  assign bus.ovf_err   = ovf_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= bus.ch_data;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= 6'd0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 6'd1;
      end else if (pop && !push) begin
        cnt <= cnt - 6'd1;
      end
    end
  end

  // Watchdog saturates at terminal count; the error flag only clears on reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wd_cnt <= 10'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (stall) begin
        if (wd_cnt == WD_TC) begin
          ovf_q <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 10'd1;
        end
      end else begin
        wd_cnt <= 10'd0;
      end
    end
  end
endmodule

// File: tb/tb_chnl_responder.sv
// Directed bench for chnl_responder (DEPTH=32, DW=32).
module tb_chnl_responder;
  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;

  chnl_responder_if #(.DW(32)) bus();

  chnl_responder #(.DEPTH(32), .DW(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.en = 1'b1;
    bus.ch_valid = 1'b0;
    bus.ch_data = 32'h0;
    bus.out_ready = 1'b0;
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    tests++; if (bus.ch_ready !== 1'b0) begin fails++; $display("FAIL reset_ch_ready got %b want 0", bus.ch_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.ch_margin !== 6'd32) begin fails++; $display("FAIL reset_margin got %0d want 32", bus.ch_margin); end
    tests++; if (bus.ovf_err !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", bus.ovf_err); end
    rstn = 1'b0;
    #1;
    tests++; if (bus.ch_ready !== 1'b1) begin fails++; $display("FAIL release_ch_ready got %b want 1", bus.ch_ready); end
    tests++; if (bus.ch_margin !== 6'd32) begin fails++; $display("FAIL release_margin got %0d want 32", bus.ch_margin); end
    tick();
  endtask

  task automatic test_single_word();
    bus.ch_data = 32'hDEADBEEF;
    bus.ch_valid = 1'b1;
    tick();
    bus.ch_valid = 1'b0;
    bus.ch_data = 32'h0;
    #1;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_out_data got %h want deadbeef", bus.out_data); end
    tests++; if (bus.ch_margin !== 6'd31) begin fails++; $display("FAIL single_margin got %0d want 31", bus.ch_margin); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    tests++; if (bus.ch_margin !== 6'd32) begin fails++; $display("FAIL single_pop_margin got %0d want 32", bus.ch_margin); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_pop_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      bus.ch_data = 32'hA000_0000 + 32'(i);
      bus.ch_valid = 1'b1;
      tick();
    end
    bus.ch_data = 32'hA000_0020;
    #1;
    tests++; if (bus.ch_margin !== 6'd0) begin fails++; $display("FAIL fill_margin got %0d want 0", bus.ch_margin); end
    tests++; if (bus.ch_ready !== 1'b0) begin fails++; $display("FAIL fill_ch_ready got %b want 0", bus.ch_ready); end
    tests++; if (bus.out_data !== 32'hA000_0000) begin fails++; $display("FAIL fill_head got %h want a0000000", bus.out_data); end
    tick();
    tests++; if (bus.ch_margin !== 6'd0) begin fails++; $display("FAIL fill_hold_margin got %0d want 0", bus.ch_margin); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    tests++; if (bus.ch_margin !== 6'd1) begin fails++; $display("FAIL fill_pop_margin got %0d want 1", bus.ch_margin); end
    tests++; if (bus.ch_ready !== 1'b1) begin fails++; $display("FAIL fill_pop_ready got %b want 1", bus.ch_ready); end
    tests++; if (bus.out_data !== 32'hA000_0001) begin fails++; $display("FAIL fill_pop_head got %h want a0000001", bus.out_data); end
    tick();
    bus.ch_valid = 1'b0;
    #1;
    tests++; if (bus.ch_margin !== 6'd0) begin fails++; $display("FAIL fill_33rd_margin got %0d want 0", bus.ch_margin); end
    for (int i = 0; i < 32; i++) begin
      bus.out_ready = 1'b1;
      #1;
      tests++;
      if (bus.out_data !== 32'hA000_0001 + 32'(i)) begin
        fails++;
        $display("FAIL fill_order[%0d] got %h want %h", i, bus.out_data, 32'hA000_0001 + 32'(i));
      end
      tick();
    end
    bus.out_ready = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL fill_drained_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.ch_margin !== 6'd32) begin fails++; $display("FAIL fill_drained_margin got %0d want 32", bus.ch_margin); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_q [100];
    int wr = 0;
    int rd = 0;
    for (int i = 0; i < 100; i++) exp_q[i] = $urandom;
    for (int c = 0; c <= 101; c++) begin
      bus.out_ready = 1'b1;
      bus.ch_valid = (wr < 100);
      if (wr < 100) bus.ch_data = exp_q[wr];
      #1;
      tests++;
      if (bus.out_valid !== ((c >= 1) && (c <= 100))) begin
        fails++;
        $display("FAIL stream_valid[%0d] got %b want %b", c, bus.out_valid, (c >= 1) && (c <= 100));
      end
      if (bus.out_valid === 1'b1 && rd < 100) begin
        tests++;
        if (bus.out_data !== exp_q[rd]) begin
          fails++;
          $display("FAIL stream_data[%0d] got %h want %h", rd, bus.out_data, exp_q[rd]);
        end
        rd++;
      end
      tests++; if (bus.ch_margin < 6'd31) begin fails++; $display("FAIL stream_margin[%0d] got %0d want >=31", c, bus.ch_margin); end
      if (bus.ch_valid && bus.ch_ready) wr++;
      tick();
    end
    bus.ch_valid = 1'b0;
    bus.out_ready = 1'b0;
    tests++; if (rd != 100) begin fails++; $display("FAIL stream_count got %0d want 100", rd); end
  endtask

  task automatic test_enable_watchdog();
    bus.en = 1'b0;
    bus.ch_valid = 1'b1;
    bus.ch_data = 32'h5555_AAAA;
    #1;
    tests++; if (bus.ch_ready !== 1'b0) begin fails++; $display("FAIL en_ready got %b want 0", bus.ch_ready); end
    tick();
    tests++; if (bus.ch_margin !== 6'd32) begin fails++; $display("FAIL en_margin got %0d want 32", bus.ch_margin); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL en_out_valid got %b want 0", bus.out_valid); end
    bus.en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.ch_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    for (int i = 0; i < 1023; i++) tick();
    tests++; if (bus.ovf_err !== 1'b0) begin fails++; $display("FAIL wd_1023 got %b want 0", bus.ovf_err); end
    tick();
    tests++; if (bus.ovf_err !== 1'b1) begin fails++; $display("FAIL wd_1024 got %b want 1", bus.ovf_err); end
    bus.ch_valid = 1'b0;
    bus.en = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    bus.out_ready = 1'b0;
    bus.en = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL en_drain_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.ovf_err !== 1'b1) begin fails++; $display("FAIL wd_sticky got %b want 1", bus.ovf_err); end
  endtask

  task automatic test_midburst_reset();
    for (int i = 0; i < 10; i++) begin
      bus.ch_data = 32'hC000_0000 + 32'(i);
      bus.ch_valid = 1'b1;
      tick();
    end
    tests++; if (bus.ch_margin !== 6'd22) begin fails++; $display("FAIL burst_margin got %0d want 22", bus.ch_margin); end
    #2;
    rstn = 1'b1;
    #1;
    tests++; if (bus.ch_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got %b want 0", bus.ch_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.ch_margin !== 6'd32) begin fails++; $display("FAIL mid_rst_margin got %0d want 32", bus.ch_margin); end
    tests++; if (bus.ovf_err !== 1'b0) begin fails++; $display("FAIL mid_rst_ovf got %b want 0", bus.ovf_err); end
    for (int i = 0; i < 3; i++) tick();
    bus.ch_valid = 1'b0;
    rstn = 1'b0;
    #1;
    tests++; if (bus.ch_margin !== 6'd32) begin fails++; $display("FAIL post_rst_margin got %0d want 32", bus.ch_margin); end
    for (int i = 0; i < 3; i++) tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL post_rst_stale got %b want 0", bus.out_valid); end
    bus.ch_data = 32'h1234_5678;
    bus.ch_valid = 1'b1;
    tick();
    bus.ch_valid = 1'b0;
    #1;
    tests++; if (bus.out_data !== 32'h1234_5678) begin fails++; $display("FAIL post_rst_data got %h want 12345678", bus.out_data); end
    tests++; if (bus.ch_margin !== 6'd31) begin fails++; $display("FAIL post_rst_push_margin got %0d want 31", bus.ch_margin); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_streaming();
    test_enable_watchdog();
    test_midburst_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule
